vga_scan_generator: RTL
=======================

# vga_scan_generator

Drives the VGA connector for the pong display. It generates the raster scan (`PIXEL_H`/`PIXEL_V`) that the game engine consumes. It also accepts the engine's registered 3-bit `PIXEL` colour and produces aligned, blanked RGB plus horizontal and vertical sync. Default timing is 800x600 at 72 Hz from the board's 50 MHz clock, which is used directly as `VGA_CLOCK`.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FRONT`, 56: horizontal front porch, in clocks
- `H_SYNC`, 120: horizontal sync width, in clocks
- `H_BACK`, 64: horizontal back porch, in clocks
- `V_ACTIVE`, 600: visible lines per frame
- `V_FRONT`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vertical sync width, in lines
- `V_BACK`, 23: vertical back porch, in lines
- `HS_POL`, 1: active level of `VGA_HS`
- `VS_POL`, 1: active level of `VGA_VS`
- `PIPE`, 2: clocks from a `PIXEL_H`/`PIXEL_V` update to the matching RGB at the pins

Ports:
- `VGA_CLOCK` input 1: pixel clock, the only clock in the block
- `RESET_N` input 1: reset, asynchronous assert, active low
- `PIXEL` input 3: colour from the game engine, {R,G,B}; it corresponds to the coordinates presented one clock earlier
- `PIXEL_H` output 11: current horizontal count, 0..H_TOTAL-1
- `PIXEL_V` output 11: current vertical count, 0..V_TOTAL-1
- `FRAME_END` output 1: one-clock pulse at the start of vertical blanking
- `VGA_R`, `VGA_G`, `VGA_B` output 1 each: pixel colour, forced to 0 outside the active area
- `VGA_HS` output 1: horizontal sync
- `VGA_VS` output 1: vertical sync

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK` (default 1040); `V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK` (default 666). All counter arithmetic is 11-bit unsigned, so totals must not exceed 2047.
- **Horizontal counter:** increments every clock. At `H_TOTAL-1` it wraps to 0.
- **Vertical counter:** increments only when the horizontal counter wraps. At `V_TOTAL-1` it wraps to 0 on that same clock.
- `PIXEL_H`/`PIXEL_V` are the counter registers themselves, with no offset or gating.
- **Active region:** `PIXEL_H < H_ACTIVE` and `PIXEL_V < V_ACTIVE`.
- **Horizontal sync:** active while `H_ACTIVE+H_FRONT <= PIXEL_H < H_ACTIVE+H_FRONT+H_SYNC`. Default range is 856..975.
- **Vertical sync:** active while `V_ACTIVE+V_FRONT <= PIXEL_V < V_ACTIVE+V_FRONT+V_SYNC`. Default range is 637..642. It spans whole lines, changing level only on a clock where `PIXEL_H == 0`.
- **Pipeline alignment:** `active`, `hs` and `vs` are computed from the counters. They pass through a shift register so they reach the pins `PIPE` clocks after the counter value that produced them.
- **Colour output:** RGB is registered from `PIXEL` on each clock, then ANDed with the delayed `active`. RGB is therefore 0 whenever the delayed position is blanked, whatever `PIXEL` holds.
- **`FRAME_END`:** registered. It is high for exactly one clock, the clock in which `PIXEL_H == 0` and `PIXEL_V == V_ACTIVE`. It is not delayed by `PIPE`. The game logic uses it to advance state once per frame.

## Timing
- **Reset** (`RESET_N` low, asynchronous):
  - `PIXEL_H` = 0, `PIXEL_V` = 0, `FRAME_END` = 0.
  - RGB = 0.
  - `VGA_HS` = ~`HS_POL`, `VGA_VS` = ~`VS_POL`.
  - All pipeline stages clear to blanked and sync-inactive.
- **Release:** on the first clock after `RESET_N` rises, `PIXEL_H` becomes 1.
- **Reset mid-frame:** the scan restarts at (0,0) with no partial sync pulse. Outputs reach their reset levels immediately, without waiting for a clock edge.
- **RGB latency:** `PIXEL_H`/`PIXEL_V` change at edge n, the game engine registers `PIXEL` at edge n+1, and the RGB pins update at edge n+2 (`PIPE` = 2). The sync outputs are delayed by the same amount.
- **Line and frame period:** one line is exactly `H_TOTAL` clocks and one frame is exactly `H_TOTAL*V_TOTAL` clocks. Defaults are 1040 clocks per line and 692,640 clocks per frame, which is 72.19 Hz at 50 MHz.
- **Simultaneous wrap:** at (`H_TOTAL-1`, `V_TOTAL-1`) both counters return to 0 on the same edge.
- **`FRAME_END` rate:** exactly one pulse per frame.

## Test plan
- **Reset hold:** hold `RESET_N` low for 10 clocks, then release.
  - During reset: all outputs at their reset values, with `VGA_HS` = `VGA_VS` = 0 at default polarity.
  - After release: `PIXEL_H` steps 1,2,3,… on successive clocks.
- **Line timing:** run 3 lines.
  - Horizontal counter wraps from 1039 to 0 while `PIXEL_V` goes 0→1.
  - `VGA_HS` rises at the 858th clock after line start (count 856 + 2 pipeline clocks) and stays high for exactly 120 clocks.
- **Full frame:** run 2 frames.
  - `FRAME_END` pulses exactly once per 692,640 clocks, at `PIXEL_H` = 0, `PIXEL_V` = 600.
  - `VGA_VS` is high for 6×1040 = 6,240 clocks.
  - Vertical counter wraps from 665 to 0.
- **Blanking and alignment:**
  - Drive `PIXEL` = 3'b111 constantly: RGB is 1 only for 800 clocks per line on lines 0..599, and 0 elsewhere, including lines 600..665.
  - Drive `PIXEL` = 3'b101 only for the clock after `PIXEL_H` = 5: `VGA_R`=1, `VGA_G`=0, `VGA_B`=1 appear exactly 2 clocks after `PIXEL_H` = 5, for one clock.
- **Asynchronous reset mid-frame:** drop `RESET_N` at (`PIXEL_H` 900, `PIXEL_V` 640), i.e. during horizontal and vertical sync.
  - Both sync outputs go inactive without waiting for a clock, and the counters read 0.
  - After release, the next `FRAME_END` arrives after exactly 600×1040 clocks.
- **Parameter override:** set `H_ACTIVE`=16, `H_FRONT`=2, `H_SYNC`=3, `H_BACK`=3, `V_ACTIVE`=4, `V_FRONT`=1, `V_SYNC`=1, `V_BACK`=1, `HS_POL`=0.
  - Line period is 24 clocks and frame period is 168 clocks.
  - `VGA_HS` is low for 3 clocks per line.

Source files
------------

// File: rtl/vga_scan_generator.sv
// VGA raster scan, sync and blanked colour generator for the pong display.
// Latency: PIXEL_H/PIXEL_V are the live counters; RGB and sync reach the pins PIPE clocks after the counter value.
// Backpressure: none. The scan free-runs every clock, and the engine must supply PIXEL one clock after the coordinates.
module vga_scan_generator #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE     = 2
) (
  input  logic        VGA_CLOCK,
  input  logic        RESET_N,
  input  logic [2:0]  PIXEL,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic        FRAME_END,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  // All scan arithmetic is 11-bit unsigned.
  localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        h_last;
  logic        v_last;
  logic        active_now;
  logic        hs_now;
  logic        vs_now;
  logic        frame_end;

  // Pipeline stages hold "active"/"sync asserted" in positive logic; polarity is applied at the pins
  // so that a cleared stage always means blanked and sync-inactive.
  logic [PIPE-1:0] act_pipe;
  logic [PIPE-1:0] hs_pipe;
  logic [PIPE-1:0] vs_pipe;
  logic [2:0]      rgb_q;

  // Next counter values: horizontal wraps each line, vertical advances only on a horizontal wrap.
  always_comb begin
    h_last = (h_cnt == H_TOTAL - 11'd1);
    v_last = (v_cnt == V_TOTAL - 11'd1);
    h_next = h_last ? 11'd0 : h_cnt + 11'd1;
    v_next = v_cnt;
    if (h_last) begin
      v_next = v_last ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Region and sync decode from the current counter values, before pipeline alignment.
  always_comb begin
    active_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_now     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_now     = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  // Scan counters and the frame-end strobe, which marks the first clock of vertical blanking.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt     <= 11'd0;
      v_cnt     <= 11'd0;
      frame_end <= 1'b0;
    end else begin
      h_cnt     <= h_next;
      v_cnt     <= v_next;
      frame_end <= (h_next == 11'd0) && (v_next == V_ACT);
    end
  end

  // Delay line aligning active/sync with the colour the engine returns for the same position.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      act_pipe[0] <= active_now;
      hs_pipe[0]  <= hs_now;
      vs_pipe[0]  <= vs_now;
      for (int i = 1; i < PIPE; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  // Capture the engine colour; it arrives one clock after its coordinates.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= PIXEL;
    end
  end

  assign PIXEL_H   = h_cnt;
  assign PIXEL_V   = v_cnt;
  assign FRAME_END = frame_end;

  // Colour is forced dark whenever the aligned position lies in blanking.
  assign VGA_R = rgb_q[2] & act_pipe[PIPE-1];
  assign VGA_G = rgb_q[1] & act_pipe[PIPE-1];
  assign VGA_B = rgb_q[0] & act_pipe[PIPE-1];

  assign VGA_HS = hs_pipe[PIPE-1] ? HS_POL : ~HS_POL;
  assign VGA_VS = vs_pipe[PIPE-1] ? VS_POL : ~VS_POL;

endmodule
